// File: rtl/gdu_pkg.sv
// rtl/gdu_pkg.sv - shared VGA timing, frame geometry and fetch-state encoding
// Contents: 640x480@60 timing constants, framebuffer line width in words,
//           fetch FSM state type/encodings, frame size helper.
package gdu_pkg;

    localparam int H_TOTAL        = 800;
    localparam int HS_START       = 656;
    localparam int HS_END         = 752;
    localparam int V_TOTAL        = 525;
    localparam int VS_START       = 490;
    localparam int VS_END         = 492;
    localparam int WORDS_PER_LINE = 320;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FS_IDLE      = 2'd0;
    localparam fetch_state_t FS_REQ       = 2'd1;
    localparam fetch_state_t FS_WAIT_DATA = 2'd2;
    localparam fetch_state_t FS_RESTART   = 2'd3;

    // Two 16-bit pixels per 32-bit framebuffer word.
    function automatic int frame_words(input int h_active, input int v_active);
        return (h_active / 2) * v_active;
    endfunction

endpackage

// File: rtl/frame_scanout_reader_if.sv
// rtl/frame_scanout_reader_if.sv - Avalon-MM burst read bus between scanout reader and framebuffer
// Signals: avm_address/avm_burstcount/avm_byteenable/avm_read (master -> slave),
//          avm_readdata/avm_readdatavalid/avm_waitrequest (slave -> master).
interface frame_scanout_reader_if;
    logic [31:0] avm_address;
    logic [3:0]  avm_burstcount;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_burstcount, avm_byteenable, avm_read,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_burstcount, avm_byteenable, avm_read,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/frame_scanout_reader_scanout_fifo.sv
// rtl/frame_scanout_reader_scanout_fifo.sv - 32-bit first-word-fall-through line FIFO
// Ports: clk0, reset (sync, active-high); push/wdata write side; pop/rdata read side
//        (rdata is the current head); flush empties the FIFO and overrides push/pop;
//        empty flag; free = DEPTH - occupancy. DEPTH must be a power of two.
module scanout_fifo #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk0,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [31:0]   rdata,
    output logic          empty,
    output logic [CW-1:0] free
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk0) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk0) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = CW'(DEPTH) - count;
endmodule

// File: rtl/frame_scanout_reader.sv
// rtl/frame_scanout_reader.sv - framebuffer burst fetcher, line FIFO and VGA timing/pixel output
// Ports: clk0, reset (sync, active-high); pix_en pixel strobe; frame_address (latched at restart);
//        avm Avalon-MM burst read master; vga_hs/vga_vs (active-low), vga_blank_n, vga_pixel;
//        frame_start pulse on vcount wrap; underflow sticky flag cleared at frame start.
module frame_scanout_reader
    import gdu_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BURST       = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int LINE_TOTAL  = H_TOTAL,
    parameter int HSYNC_START = HS_START,
    parameter int HSYNC_END   = HS_END,
    parameter int FRAME_LINES = V_TOTAL,
    parameter int VSYNC_START = VS_START,
    parameter int VSYNC_END   = VS_END
) (
    input  logic                  clk0,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic [31:0]           frame_address,
    frame_scanout_reader_if.master avm,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_blank_n,
    output logic [15:0]           vga_pixel,
    output logic                  frame_start,
    output logic                  underflow
);
    localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int BW          = $clog2(BURST + 1);

    logic [9:0]    hcount;
    logic [9:0]    vcount;
    fetch_state_t  state;
    logic [31:0]   fetch_ptr;
    logic [17:0]   words_fetched;
    logic [BW-1:0] beat_cnt;
    logic          restart_pending;

    logic          h_last;
    logic          v_last;
    logic          active;
    logic          restart_evt;
    logic          restart_due;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic [CW-1:0] fifo_free;

    assign h_last      = (hcount == 10'(LINE_TOTAL - 1));
    assign v_last      = (vcount == 10'(FRAME_LINES - 1));
    assign active      = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    // Start of vertical blanking: the whole next frame is refetched from here.
    assign restart_evt = pix_en && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
    assign restart_due = restart_pending || restart_evt;

    assign avm.avm_burstcount = 4'(BURST);
    assign avm.avm_byteenable = 4'b1111;

    assign fifo_push  = (state == FS_WAIT_DATA) && avm.avm_readdatavalid;
    assign fifo_pop   = pix_en && active && hcount[0] && !fifo_empty;
    assign fifo_flush = (state == FS_RESTART);

    scanout_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk0  (clk0),
        .reset (reset),
        .push  (fifo_push),
        .wdata (avm.avm_readdata),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    always_ff @(posedge clk0) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    // Video outputs are computed from the pre-increment counters.
    always_ff @(posedge clk0) begin
        if (reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_pixel   <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                vga_hs      <= !((hcount >= 10'(HSYNC_START)) && (hcount < 10'(HSYNC_END)));
                vga_vs      <= !((vcount >= 10'(VSYNC_START)) && (vcount < 10'(VSYNC_END)));
                vga_blank_n <= active;
                if (active && !fifo_empty) begin
                    vga_pixel <= hcount[0] ? fifo_rdata[31:16] : fifo_rdata[15:0];
                end else begin
                    vga_pixel <= '0;
                end
            end
            if (pix_en && h_last && v_last) begin
                underflow <= 1'b0;
            end else if (pix_en && active && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Fetch FSM: one burst in flight at most; a started burst always completes
    // before a pending restart is honoured.
    always_ff @(posedge clk0) begin
        if (reset) begin
            state           <= FS_RESTART;
            fetch_ptr       <= '0;
            words_fetched   <= '0;
            beat_cnt        <= '0;
            restart_pending <= 1'b0;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= '0;
        end else begin
            if (restart_evt) restart_pending <= 1'b1;
            case (state)
                FS_IDLE: begin
                    if (restart_due) begin
                        state <= FS_RESTART;
                    end else if ((fifo_free >= CW'(BURST)) && (words_fetched < 18'(FRAME_WORDS))) begin
                        state           <= FS_REQ;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= fetch_ptr;
                    end
                end
                FS_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        avm.avm_read <= 1'b0;
                        fetch_ptr    <= fetch_ptr + 32'(BURST * 4);
                        beat_cnt     <= '0;
                        state        <= FS_WAIT_DATA;
                    end
                end
                FS_WAIT_DATA: begin
                    if (avm.avm_readdatavalid) begin
                        if (beat_cnt == BW'(BURST - 1)) begin
                            beat_cnt      <= '0;
                            words_fetched <= words_fetched + 18'(BURST);
                            state         <= restart_due ? FS_RESTART : FS_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    fetch_ptr       <= frame_address;
                    words_fetched   <= '0;
                    beat_cnt        <= '0;
                    restart_pending <= restart_evt;
                    state           <= FS_IDLE;
                end
            endcase
        end
    end
endmodule
